// File: rtl/matmul_sched_pkg.sv
// Shared definitions for the matmul sequencer: state encoding, control-register
// field layout and the dimension/index width helpers.
package matmul_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FEED,
      ST_DRAIN,
      ST_WB,
      ST_DONE
   } state_e;

   localparam int FLD_W     = 2;
   localparam int M_LSB     = 12;
   localparam int K_LSB     = 10;
   localparam int N_LSB     = 8;
   localparam int SP_LSB    = 4;
   localparam int BIAS_BIT  = 1;
   localparam int START_BIT = 0;

   function automatic int max_dim(input int bus_w, input int data_w);
      return bus_w / data_w;
   endfunction

   // Never returns 0 so that every counter/index bus is at least one bit wide.
   function automatic int min1_clog2(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/matmul_sched_skew_lane_gen.sv
// One operand-feed lane: lane LANE is active while 0 <= t-LANE < k and the lane
// lies inside the current dimension limit; inactive lanes drive kidx 0.
module matmul_sched_skew_lane_gen #(
   parameter int LANE = 0,
   parameter int TW   = 4,
   parameter int IDXW = 2
) (
   input  logic            en_i,
   input  logic [TW-1:0]   t_i,
   input  logic [TW-1:0]   lim_i,
   input  logic [TW-1:0]   k_i,
   output logic            valid_o,
   output logic [IDXW-1:0] kidx_o
);

   logic [TW-1:0] off;
   logic          hit;

   always_comb begin
      off     = t_i - TW'(LANE);
      hit     = en_i && (TW'(LANE) < lim_i) && (t_i >= TW'(LANE)) && (off < k_i);
      valid_o = hit;
      kidx_o  = hit ? off[IDXW-1:0] : '0;
   end

endmodule

// File: rtl/matmul_sched.sv
// Matrix-multiply sequencer: one operation per start edge, LOAD -> FEED -> DRAIN -> WB -> DONE.
// Every output is registered from the next-state values so it lines up with its state.
module matmul_sched
   import matmul_sched_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int BUS_WIDTH   = 32,
   parameter  int SP_NTARGETS = 4,
   parameter  int PIPE_LAT    = 1,
   localparam int MAX_DIM     = max_dim(BUS_WIDTH, DATA_WIDTH),
   localparam int IDXW        = min1_clog2(MAX_DIM)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [15:0]             control_reg_i,
   output logic                    busy_o,
   output logic                    pe_clr_o,
   output logic                    pe_bias_o,
   output logic [MAX_DIM-1:0]      a_valid_o,
   output logic [MAX_DIM*IDXW-1:0] a_kidx_o,
   output logic [MAX_DIM-1:0]      b_valid_o,
   output logic [MAX_DIM*IDXW-1:0] b_kidx_o,
   output logic                    sp_we_o,
   output logic [1:0]              sp_sel_o,
   output logic [IDXW-1:0]         sp_row_o,
   output logic                    eop_o,
   output logic                    clr_start_o
);

   // Wide enough for dims up to MAX_DIM and feed counter up to 3*MAX_DIM-3.
   localparam int TW = min1_clog2(3 * MAX_DIM);
   localparam int DW = min1_clog2(PIPE_LAT + 1);

   state_e          state_q, state_d;
   logic [TW-1:0]   t_q, t_d;
   logic [DW-1:0]   dr_q, dr_d;
   logic [IDXW-1:0] row_q, row_d;
   logic [TW-1:0]   n_q, n_d, k_q, k_d, m_q, m_d;
   logic [1:0]      sel_q, sel_d;
   logic            bias_q, bias_d;
   logic            start_prev_q, start_edge;
   logic [FLD_W-1:0] sp_fld;

   logic                    busy_q, pe_clr_q, pe_bias_q, sp_we_q, eop_q, clr_start_q;
   logic [MAX_DIM-1:0]      a_valid_q, a_valid_d, b_valid_q, b_valid_d;
   logic [MAX_DIM*IDXW-1:0] a_kidx_q, a_kidx_d, b_kidx_q, b_kidx_d;
   logic [1:0]              sp_sel_q;
   logic [IDXW-1:0]         sp_row_q;
   logic                    feed_d;
   logic                    unused_ctrl;

   assign unused_ctrl = ^{control_reg_i[15:14], control_reg_i[7:6], control_reg_i[3:2]};
   assign start_edge  = control_reg_i[START_BIT] && !start_prev_q;
   assign sp_fld      = control_reg_i[SP_LSB +: FLD_W];

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      dr_d    = dr_q;
      row_d   = row_q;
      n_d     = n_q;
      k_d     = k_q;
      m_d     = m_q;
      sel_d   = sel_q;
      bias_d  = bias_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_LOAD;
               n_d     = TW'(control_reg_i[N_LSB +: FLD_W]) + TW'(1);
               k_d     = TW'(control_reg_i[K_LSB +: FLD_W]) + TW'(1);
               m_d     = TW'(control_reg_i[M_LSB +: FLD_W]) + TW'(1);
               // Selects beyond the populated scratchpads fold back to target 0.
               sel_d   = (int'(sp_fld) < SP_NTARGETS) ? 2'(sp_fld) : 2'd0;
               bias_d  = control_reg_i[BIAS_BIT];
            end
         end
         ST_LOAD: begin
            state_d = ST_FEED;
            t_d     = '0;
         end
         ST_FEED: begin
            if (t_q == n_q + k_q + m_q - TW'(3)) begin
               t_d   = '0;
               dr_d  = '0;
               row_d = '0;
               state_d = (PIPE_LAT == 0) ? ST_WB : ST_DRAIN;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (dr_q == DW'(PIPE_LAT - 1)) begin
               state_d = ST_WB;
               row_d   = '0;
            end else begin
               dr_d = dr_q + DW'(1);
            end
         end
         ST_WB: begin
            if (TW'(row_q) == n_q - TW'(1)) state_d = ST_DONE;
            else                            row_d   = row_q + IDXW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign feed_d = (state_d == ST_FEED);

   for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
      matmul_sched_skew_lane_gen #(.LANE(i), .TW(TW), .IDXW(IDXW)) u_a_lane (
         .en_i    (feed_d),
         .t_i     (t_d),
         .lim_i   (n_d),
         .k_i     (k_d),
         .valid_o (a_valid_d[i]),
         .kidx_o  (a_kidx_d[i*IDXW +: IDXW])
      );
      matmul_sched_skew_lane_gen #(.LANE(i), .TW(TW), .IDXW(IDXW)) u_b_lane (
         .en_i    (feed_d),
         .t_i     (t_d),
         .lim_i   (m_d),
         .k_i     (k_d),
         .valid_o (b_valid_d[i]),
         .kidx_o  (b_kidx_d[i*IDXW +: IDXW])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         t_q          <= '0;
         dr_q         <= '0;
         row_q        <= '0;
         n_q          <= '0;
         k_q          <= '0;
         m_q          <= '0;
         sel_q        <= '0;
         bias_q       <= 1'b0;
         start_prev_q <= 1'b0;
         busy_q       <= 1'b0;
         pe_clr_q     <= 1'b0;
         pe_bias_q    <= 1'b0;
         a_valid_q    <= '0;
         a_kidx_q     <= '0;
         b_valid_q    <= '0;
         b_kidx_q     <= '0;
         sp_we_q      <= 1'b0;
         sp_sel_q     <= '0;
         sp_row_q     <= '0;
         eop_q        <= 1'b0;
         clr_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         t_q          <= t_d;
         dr_q         <= dr_d;
         row_q        <= row_d;
         n_q          <= n_d;
         k_q          <= k_d;
         m_q          <= m_d;
         sel_q        <= sel_d;
         bias_q       <= bias_d;
         start_prev_q <= control_reg_i[START_BIT];
         busy_q       <= (state_d != ST_IDLE);
         pe_clr_q     <= (state_d == ST_LOAD) && !bias_d;
         pe_bias_q    <= (state_d == ST_LOAD) && bias_d;
         a_valid_q    <= a_valid_d;
         a_kidx_q     <= a_kidx_d;
         b_valid_q    <= b_valid_d;
         b_kidx_q     <= b_kidx_d;
         sp_we_q      <= (state_d == ST_WB);
         sp_sel_q     <= (state_d == ST_WB) ? sel_d : 2'd0;
         sp_row_q     <= (state_d == ST_WB) ? row_d : '0;
         eop_q        <= (state_d == ST_DONE);
         clr_start_q  <= (state_d == ST_DONE);
      end
   end

   assign busy_o      = busy_q;
   assign pe_clr_o    = pe_clr_q;
   assign pe_bias_o   = pe_bias_q;
   assign a_valid_o   = a_valid_q;
   assign a_kidx_o    = a_kidx_q;
   assign b_valid_o   = b_valid_q;
   assign b_kidx_o    = b_kidx_q;
   assign sp_we_o     = sp_we_q;
   assign sp_sel_o    = sp_sel_q;
   assign sp_row_o    = sp_row_q;
   assign eop_o       = eop_q;
   assign clr_start_o = clr_start_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: table of directed operations, hand-written
// reset/retrigger sequences and random operations against a per-cycle timeline model.
module tb_matmul_sched;

   localparam int P = 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ctrl;
   logic        busy, pe_clr, pe_bias, sp_we, eop, clr_start;
   logic [3:0]  a_valid, b_valid;
   logic [7:0]  a_kidx, b_kidx;
   logic [1:0]  sp_sel, sp_row;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       busy;
      logic       clr;
      logic       bias;
      logic [3:0] av;
      logic [7:0] ak;
      logic [3:0] bv;
      logic [7:0] bk;
      logic       we;
      logic [1:0] sel;
      logic [1:0] row;
      logic       eop;
      logic       clrs;
   } outs_t;

   typedef struct {
      int n, k, m, bias, sp;
   } cfg_t;

   typedef struct {
      cfg_t cfg;
      int   exp_lat;
      int   exp_rows;
   } vec_t;

   matmul_sched #(.DATA_WIDTH(8), .BUS_WIDTH(32), .SP_NTARGETS(4), .PIPE_LAT(P)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .control_reg_i (ctrl),
      .busy_o        (busy),
      .pe_clr_o      (pe_clr),
      .pe_bias_o     (pe_bias),
      .a_valid_o     (a_valid),
      .a_kidx_o      (a_kidx),
      .b_valid_o     (b_valid),
      .b_kidx_o      (b_kidx),
      .sp_we_o       (sp_we),
      .sp_sel_o      (sp_sel),
      .sp_row_o      (sp_row),
      .eop_o         (eop),
      .clr_start_o   (clr_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ctrl_word(input cfg_t c, input logic start);
      logic [15:0] w;
      w        = '0;
      w[13:12] = 2'(c.m - 1);
      w[11:10] = 2'(c.k - 1);
      w[9:8]   = 2'(c.n - 1);
      w[5:4]   = 2'(c.sp);
      w[1]     = (c.bias != 0);
      w[0]     = start;
      return w;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o = {busy, pe_clr, pe_bias, a_valid, a_kidx, b_valid, b_kidx,
           sp_we, sp_sel, sp_row, eop, clr_start};
      return o;
   endfunction

   // Expected outputs cyc cycles after the start edge, laid out as a phase timeline.
   function automatic outs_t model(input cfg_t c, input int cyc);
      outs_t o;
      int    feed_len, t, wb0, done_c;
      o        = '0;
      feed_len = c.k + c.n + c.m - 2;
      wb0      = 2 + feed_len + P;
      done_c   = wb0 + c.n;
      if (cyc == 1) begin
         o.busy = 1'b1;
         o.clr  = (c.bias == 0);
         o.bias = (c.bias != 0);
      end else if (cyc >= 2 && cyc < 2 + feed_len) begin
         o.busy = 1'b1;
         t = cyc - 2;
         for (int i = 0; i < 4; i++) begin
            if (i < c.n && t - i >= 0 && t - i < c.k) begin
               o.av[i] = 1'b1;
               o.ak[i*2 +: 2] = 2'(t - i);
            end
            if (i < c.m && t - i >= 0 && t - i < c.k) begin
               o.bv[i] = 1'b1;
               o.bk[i*2 +: 2] = 2'(t - i);
            end
         end
      end else if (cyc >= 2 + feed_len && cyc < wb0) begin
         o.busy = 1'b1;
      end else if (cyc >= wb0 && cyc < done_c) begin
         o.busy = 1'b1;
         o.we   = 1'b1;
         o.sel  = 2'(c.sp);
         o.row  = 2'(cyc - wb0);
      end else if (cyc == done_c) begin
         o.busy = 1'b1;
         o.eop  = 1'b1;
         o.clrs = 1'b1;
      end
      return o;
   endfunction

   task automatic check_out(input string name, input int cyc, input outs_t got, input outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // mode 0: drop start at cycle 2; 1: hold start high; 2: extra edge during FEED;
   // 3: scramble the config fields during FEED with start still high.
   task automatic run_op(input string name, input cfg_t c, input int mode,
                         output int eop_cyc, output int eop_cnt, output int rows);
      int    lat;
      cfg_t  junk;
      outs_t got;
      lat     = 2 + (c.k + c.n + c.m - 2) + P + c.n;
      eop_cyc = -1;
      eop_cnt = 0;
      rows    = 0;
      ctrl    = ctrl_word(c, 1'b0);
      tick();
      ctrl = ctrl_word(c, 1'b1);
      for (int cy = 1; cy <= lat + 3; cy++) begin
         tick();
         got = sample();
         check_out(name, cy, got, model(c, cy));
         if (got.eop) begin
            eop_cnt++;
            eop_cyc = cy;
         end
         if (got.we) rows++;
         if ((mode == 0 || mode == 2) && cy == 2) ctrl[0] = 1'b0;
         if (mode == 2 && cy == 4) ctrl[0] = 1'b1;
         if (mode == 3 && cy == 3) begin
            junk.n = 5 - c.n; junk.k = 5 - c.k; junk.m = 5 - c.m;
            junk.bias = 1 - c.bias; junk.sp = 3 - c.sp;
            ctrl = ctrl_word(junk, 1'b1);
         end
      end
      ctrl = '0;
      tick();
   endtask

   vec_t  vecs[5];
   cfg_t  c;
   int    ec, en, nr;

   initial begin
      vecs[0] = '{cfg: '{n: 4, k: 4, m: 4, bias: 0, sp: 2}, exp_lat: 17, exp_rows: 4};
      vecs[1] = '{cfg: '{n: 1, k: 1, m: 1, bias: 1, sp: 0}, exp_lat: 5,  exp_rows: 1};
      vecs[2] = '{cfg: '{n: 2, k: 3, m: 4, bias: 0, sp: 1}, exp_lat: 12, exp_rows: 2};
      vecs[3] = '{cfg: '{n: 3, k: 1, m: 2, bias: 1, sp: 3}, exp_lat: 10, exp_rows: 3};
      vecs[4] = '{cfg: '{n: 4, k: 2, m: 1, bias: 0, sp: 0}, exp_lat: 12, exp_rows: 4};

      rst  = 1'b1;
      ctrl = '0;
      tick();
      tick();
      check_out("reset", 0, sample(), '0);
      rst = 1'b0;
      tick();
      check_out("idle_after_reset", 0, sample(), '0);

      for (int v = 0; v < 5; v++) begin
         run_op("table_seq", vecs[v].cfg, 0, ec, en, nr);
         check_int("table_eop_cycle", ec, vecs[v].exp_lat);
         check_int("table_eop_count", en, 1);
         check_int("table_wb_rows", nr, vecs[v].exp_rows);
      end

      // Start held high, then an extra edge while busy: one operation each time.
      run_op("hold_high", vecs[0].cfg, 1, ec, en, nr);
      check_int("hold_high_eop_count", en, 1);
      run_op("extra_edge", vecs[2].cfg, 2, ec, en, nr);
      check_int("extra_edge_eop_count", en, 1);
      check_int("extra_edge_eop_cycle", ec, 12);

      // Dims rewritten during FEED must not change the running operation.
      run_op("cfg_change", vecs[0].cfg, 3, ec, en, nr);
      check_int("cfg_change_eop_cycle", ec, 17);
      check_int("cfg_change_rows", nr, 4);

      // Reset in the middle of FEED aborts with no eop.
      c    = vecs[0].cfg;
      ctrl = ctrl_word(c, 1'b0);
      tick();
      ctrl = ctrl_word(c, 1'b1);
      for (int cy = 1; cy <= 5; cy++) begin
         tick();
         check_out("pre_reset", cy, sample(), model(c, cy));
      end
      rst  = 1'b1;
      ctrl = '0;
      tick();
      check_out("reset_mid_feed", 6, sample(), '0);
      rst = 1'b0;
      for (int cy = 7; cy < 27; cy++) begin
         tick();
         check_out("after_abort_idle", cy, sample(), '0);
      end
      run_op("post_reset", vecs[0].cfg, 0, ec, en, nr);
      check_int("post_reset_eop_cycle", ec, 17);
      check_int("post_reset_eop_count", en, 1);

      for (int r = 0; r < 25; r++) begin
         c.n    = $urandom_range(1, 4);
         c.k    = $urandom_range(1, 4);
         c.m    = $urandom_range(1, 4);
         c.bias = $urandom_range(0, 1);
         c.sp   = $urandom_range(0, 3);
         run_op("random", c, $urandom_range(0, 3), ec, en, nr);
         check_int("random_eop_count", en, 1);
         check_int("random_rows", nr, c.n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
